// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), one
// input bit per clock. Drives the packed-nibble X input of the 4-digit
// 7-segment displayer: digit 3 in [15:12], digit 0 in [3:0]. The published
// result is held stable between conversions so the multiplexed display never
// shows a partially converted value.
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   start  conversion request, sampled only while idle
//   bin    binary value, captured on the edge that accepts start
//   bcd    packed BCD result (DIGITS*4 bits), updated only on completion
//   busy   high while a conversion is in progress
//   done   one-cycle pulse when bcd has just been updated
//   ovf    last accepted bin exceeded MAX_VAL (result clamped), held until
//          the next completion
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int MAX_VAL = 9999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(BIN_W);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd_acc;
  logic [BIN_W-1:0]   bin_acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;

  logic [BCD_W-1:0]   bcd_adj;
  logic               ovf_next;
  logic [BIN_W-1:0]   bin_load;

  // Add-3 correction: every digit that is 5 or more gets +3 before the shift,
  // all digits judged on their pre-shift values. A digit of at most 9 never
  // exceeds 12 after the add, so no carry crosses into the next nibble.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_acc[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd_acc[d*4 +: 4] + 4'd3;
      end
    end
  end

  // Saturation: values above MAX_VAL are converted as MAX_VAL and flagged.
  always_comb begin
    ovf_next = (bin > MAX_BIN);
    bin_load = ovf_next ? MAX_BIN : bin;
  end

  // Control FSM and datapath. bcd and ovf are only written in DONE (or by
  // reset), so the scratch register's intermediate values never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bcd_acc  <= '0;
      bin_acc  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bcd_acc  <= '0;
            bin_acc  <= bin_load;
            ovf_pend <= ovf_next;
            cnt      <= CNT_START;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end

        CONV: begin
          {bcd_acc, bin_acc} <= {bcd_adj, bin_acc} << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end

        DONE: begin
          bcd   <= bcd_acc;
          ovf   <= ovf_pend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed self-checking bench for bin_to_bcd_seq. Edge numbering follows the
// design's latency description: edge 0 accepts start, edge 15 publishes the
// result. Inputs change on falling edges, outputs are sampled 1 time unit
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        ovf;

  int checksTotal;
  int checksPassed;

  // Last result the bench expects the DUT to be holding on bcd/ovf.
  logic [15:0] modelBcd;
  logic        modelOvf;

  bin_to_bcd_seq #(
    .BIN_W  (14),
    .DIGITS (4),
    .MAX_VAL(9999)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bin  (bin),
    .bcd  (bcd),
    .busy (busy),
    .done (done),
    .ovf  (ovf)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch reports tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checksTotal++;
    assert (observed === expected) begin
      checksPassed++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%04h, expected 0x%04h", tag, observed, expected);
    end
  endtask

  // Drive the request inputs on a falling edge, ahead of the next rising edge.
  task automatic applyStimulus(input logic startV, input logic [13:0] binV);
    @(negedge clk);
    start = startV;
    bin   = binV;
  endtask

  // Run one conversion from request through the done edge (edges 0..15).
  // hold keeps start high the whole time (bin untouched); otherwise start is
  // dropped after acceptance and bin is scrambled to prove it was captured.
  // glitchEdge > 0 re-pulses start with glitchBin at that edge while busy.
  task automatic runConversion(input string tag, input logic [13:0] binV,
                               input logic [15:0] expBcd, input logic expOvf,
                               input bit hold, input int glitchEdge,
                               input logic [13:0] glitchBin);
    applyStimulus(1'b1, binV);
    for (int e = 0; e <= 15; e++) begin
      @(posedge clk);
      #1;
      if (e < 15) begin
        checkOutput($sformatf("%s busy@%0d", tag, e), {15'd0, busy}, 16'd1);
        checkOutput($sformatf("%s done@%0d", tag, e), {15'd0, done}, 16'd0);
        checkOutput($sformatf("%s bcd@%0d", tag, e), bcd, modelBcd);
        checkOutput($sformatf("%s ovf@%0d", tag, e), {15'd0, ovf}, {15'd0, modelOvf});
      end else begin
        checkOutput($sformatf("%s busy@15", tag), {15'd0, busy}, 16'd0);
        checkOutput($sformatf("%s done@15", tag), {15'd0, done}, 16'd1);
        checkOutput($sformatf("%s bcd@15", tag), bcd, expBcd);
        checkOutput($sformatf("%s ovf@15", tag), {15'd0, ovf}, {15'd0, expOvf});
        modelBcd = expBcd;
        modelOvf = expOvf;
      end
      if (e < 15 && !hold) begin
        if (e + 1 == glitchEdge) begin
          applyStimulus(1'b1, glitchBin);
        end else begin
          applyStimulus(1'b0, 14'($urandom_range(0, 16383)));
        end
      end
    end
  endtask

  // Idle cycle after a completion: done must have fallen, result must hold.
  task automatic checkIdle(input string tag);
    applyStimulus(1'b0, 14'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, " idle done"}, {15'd0, done}, 16'd0);
    checkOutput({tag, " idle busy"}, {15'd0, busy}, 16'd0);
    checkOutput({tag, " idle bcd"}, bcd, modelBcd);
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    modelBcd     = 16'h0000;
    modelOvf     = 1'b0;
    start        = 1'b0;
    bin          = 14'd0;
    rst_n        = 1'b0;

    // Reset state
    #12;
    checkOutput("reset bcd", bcd, 16'h0000);
    checkOutput("reset busy", {15'd0, busy}, 16'd0);
    checkOutput("reset done", {15'd0, done}, 16'd0);
    checkOutput("reset ovf", {15'd0, ovf}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkIdle("post-reset");

    // Zero, then a typical value
    runConversion("bin0", 14'd0, 16'h0000, 1'b0, 1'b0, 0, 14'd0);
    checkIdle("bin0");
    runConversion("bin1234", 14'd1234, 16'h1234, 1'b0, 1'b0, 0, 14'd0);
    checkIdle("bin1234");

    // Saturation boundary and recovery
    runConversion("bin9999", 14'd9999, 16'h9999, 1'b0, 1'b0, 0, 14'd0);
    runConversion("bin12000", 14'd12000, 16'h9999, 1'b1, 1'b0, 0, 14'd0);
    runConversion("bin7", 14'd7, 16'h0007, 1'b0, 1'b0, 0, 14'd0);
    runConversion("bin10000", 14'd10000, 16'h9999, 1'b1, 1'b0, 0, 14'd0);
    runConversion("bin16383", 14'd16383, 16'h9999, 1'b1, 1'b0, 0, 14'd0);
    runConversion("bin8765", 14'd8765, 16'h8765, 1'b0, 1'b0, 0, 14'd0);
    checkIdle("bin8765");

    // Request while busy is ignored
    runConversion("bin42", 14'd42, 16'h0042, 1'b0, 1'b0, 5, 14'd800);
    checkIdle("bin42");

    // start held high: back-to-back conversions, 16 cycles apart
    runConversion("b2b500", 14'd500, 16'h0500, 1'b0, 1'b1, 0, 14'd0);
    runConversion("b2b501", 14'd501, 16'h0501, 1'b0, 1'b1, 0, 14'd0);
    checkIdle("b2b501");

    // Reset in the middle of a conversion
    runConversion("pre-rst1234", 14'd1234, 16'h1234, 1'b0, 1'b0, 0, 14'd0);
    applyStimulus(1'b1, 14'd5678);
    @(posedge clk);
    #1;
    checkOutput("rst-mid busy@0", {15'd0, busy}, 16'd1);
    applyStimulus(1'b0, 14'd5678);
    repeat (6) @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst-mid bcd", bcd, 16'h0000);
    checkOutput("rst-mid busy", {15'd0, busy}, 16'd0);
    checkOutput("rst-mid done", {15'd0, done}, 16'd0);
    modelBcd = 16'h0000;
    modelOvf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rst-mid no done %0d", i), {15'd0, done}, 16'd0);
    end
    checkOutput("rst-mid bcd held", bcd, 16'h0000);
    runConversion("post-rst5678", 14'd5678, 16'h5678, 1'b0, 1'b0, 0, 14'd0);
    checkIdle("post-rst5678");

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
